uart_avm_controller: RTL and testbench

//   Avalon-MM master that sequences the RS232 UART core on the 25 MHz system clock.

---
 rtl/uart_ctrl_pkg.sv | 28 ++
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_avm_controller.sv | 173 +++++++++++++++++
 tb/tb_uart_avm_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and default register map for the UART Avalon-MM controller.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_STATUS,
      DECIDE,
      RD_DATA,
      WR_DATA
   } state_e;

   typedef enum logic {
      GRANT_RX,
      GRANT_TX
   } grant_e;

   localparam logic [4:0] RXDATA_OFS_DEF = 5'd0;
   localparam logic [4:0] TXDATA_OFS_DEF = 5'd4;
   localparam logic [4:0] STATUS_OFS_DEF = 5'd8;
   localparam int         RRDY_BIT_DEF   = 7;
   localparam int         TRDY_BIT_DEF   = 6;

   // Round-robin: when both sides contend, hand the bus to the one not served last.
   function automatic grant_e rr_pick(input grant_e last);
      return (last == GRANT_RX) ? GRANT_TX : GRANT_RX;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO; power-of-two depth so pointers wrap naturally.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [7:0]               push_data_i,
   input  logic                     pop_i,
   output logic [7:0]               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   // Empty FIFO shows zero rather than stale storage.
   assign head_o  = empty_o ? 8'd0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_avm_controller.sv
// Avalon-MM master polling a UART: drains RX into a FIFO, writes TX bytes, round-robin bus sharing.
// Optional build macro UART_CTRL_ECHO_EN loops every received byte back out through the UART.
module uart_avm_controller
   import uart_ctrl_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [4:0] RXDATA_OFS = RXDATA_OFS_DEF,
   parameter logic [4:0] TXDATA_OFS = TXDATA_OFS_DEF,
   parameter logic [4:0] STATUS_OFS = STATUS_OFS_DEF,
   parameter int         RRDY_BIT   = RRDY_BIT_DEF,
   parameter int         TRDY_BIT   = TRDY_BIT_DEF
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   output logic [4:0]  avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        rx_stall,
   output logic        busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e        state_q;
   grant_e        last_grant_q, grant_d;
   logic          rrdy_q, trdy_q;
   logic          read_q, write_q, tx_ready_q, rx_stall_q;
   logic [4:0]    addr_q;
   logic [7:0]    wdata_q;
   logic          rx_ok_d, tx_ok_d, tx_req_d;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;
   logic          unused_bits;
`ifdef UART_CTRL_ECHO_EN
   logic          echo_pend_q, echo_wr_q;
   logic [7:0]    echo_buf_q;
`endif

   assign avm_address   = addr_q;
   assign avm_read      = read_q;
   assign avm_write     = write_q;
   assign avm_writedata = {24'd0, wdata_q};
   assign tx_ready      = tx_ready_q;
   assign rx_stall      = rx_stall_q;
   assign busy          = (state_q != IDLE);
   assign rx_valid      = ~fifo_empty;
   assign rx_data       = fifo_head;
   assign unused_bits   = ^{avm_readdata[31:8], fifo_count};

   // Zero read latency: the byte is on readdata on the completing edge.
   assign fifo_push = (state_q == RD_DATA) & read_q & ~avm_waitrequest;
   assign fifo_pop  = rx_valid & rx_ready;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i       (avm_clk),
      .rst_ni      (avm_rst),
      .push_i      (fifo_push),
      .push_data_i (avm_readdata[7:0]),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   always_comb begin
      tx_req_d = tx_valid;
      rx_ok_d  = rrdy_q & ~fifo_full;
`ifdef UART_CTRL_ECHO_EN
      // A pending echo blocks further reads so echo_buf is never overwritten.
      tx_req_d = tx_valid | echo_pend_q;
      rx_ok_d  = rrdy_q & ~fifo_full & ~echo_pend_q;
`endif
      tx_ok_d  = trdy_q & tx_req_d;
      grant_d  = GRANT_RX;
      if (rx_ok_d && tx_ok_d) grant_d = rr_pick(last_grant_q);
      else if (tx_ok_d)       grant_d = GRANT_TX;
   end

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_TX;
         rrdy_q       <= 1'b0;
         trdy_q       <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 5'd0;
         wdata_q      <= 8'd0;
         tx_ready_q   <= 1'b0;
         rx_stall_q   <= 1'b0;
`ifdef UART_CTRL_ECHO_EN
         echo_pend_q  <= 1'b0;
         echo_wr_q    <= 1'b0;
         echo_buf_q   <= 8'd0;
`endif
      end else begin
         tx_ready_q <= 1'b0;
         rx_stall_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= RD_STATUS;
               read_q  <= 1'b1;
               addr_q  <= STATUS_OFS;
            end
            RD_STATUS: begin
               if (!avm_waitrequest) begin
                  read_q  <= 1'b0;
                  rrdy_q  <= avm_readdata[RRDY_BIT];
                  trdy_q  <= avm_readdata[TRDY_BIT];
                  state_q <= DECIDE;
               end
            end
            DECIDE: begin
               rx_stall_q <= rrdy_q & fifo_full;
               if (!(rx_ok_d || tx_ok_d)) begin
                  state_q <= IDLE;
               end else if (grant_d == GRANT_RX) begin
                  read_q  <= 1'b1;
                  addr_q  <= RXDATA_OFS;
                  state_q <= RD_DATA;
               end else begin
                  write_q <= 1'b1;
                  addr_q  <= TXDATA_OFS;
                  state_q <= WR_DATA;
`ifdef UART_CTRL_ECHO_EN
                  echo_wr_q <= echo_pend_q;
                  wdata_q   <= echo_pend_q ? echo_buf_q : tx_data;
`else
                  wdata_q   <= tx_data;
`endif
               end
            end
            RD_DATA: begin
               if (!avm_waitrequest) begin
                  read_q       <= 1'b0;
                  last_grant_q <= GRANT_RX;
                  state_q      <= IDLE;
`ifdef UART_CTRL_ECHO_EN
                  echo_buf_q   <= avm_readdata[7:0];
                  echo_pend_q  <= 1'b1;
`endif
               end
            end
            WR_DATA: begin
               if (!avm_waitrequest) begin
                  write_q      <= 1'b0;
                  last_grant_q <= GRANT_TX;
                  state_q      <= IDLE;
`ifdef UART_CTRL_ECHO_EN
                  if (echo_wr_q) echo_pend_q <= 1'b0;
                  else           tx_ready_q  <= 1'b1;
`else
                  tx_ready_q   <= 1'b1;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_avm_controller.sv
// Directed bench for uart_avm_controller with a small UART slave model and bus monitor.
`define CHK(tag, obs, exp) \
   begin \
      ncmp++; \
      assert ((obs) === (exp)) else begin \
         nfail++; \
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
      end \
   end

`define WAITC(cond, n) \
   begin \
      int g; \
      g = 0; \
      while (!(cond) && g < (n)) begin \
         @(negedge avm_clk); \
         g++; \
      end \
   end

module tb_uart_avm_controller;

   logic        avm_clk = 1'b0;
   logic        avm_rst = 1'b0;
   logic [4:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic [7:0]  tx_data = 8'd0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        rx_stall;
   logic        busy;

   int ncmp = 0;
   int nfail = 0;

   // Slave model state
   int          ws = 0;
   int          wcnt = 0;
   logic        trdy_en = 1'b0;
   int          rx_req = 0;
   logic [7:0]  rx_bytes [64];
   logic        rrdy;

   // Monitor state
   int          st_cnt = 0, rd_cnt = 0, wr_cnt = 0, txr_cnt = 0, stall_cnt = 0;
   int          pop_cnt = 0, gn = 0, ws_seen = 0, stab_err = 0;
   logic [4:0]  wr_addr_log [128];
   logic [31:0] wr_data_log [128];
   logic        glog [128];
   logic [7:0]  pop_log [128];
   logic        hold_q = 1'b0;
   logic [4:0]  s_addr;
   logic        s_rd, s_wr;
   logic [31:0] s_wd;

   always #20 avm_clk = ~avm_clk;

   assign rrdy            = (rx_req > rd_cnt);
   assign avm_waitrequest = (avm_read | avm_write) && (wcnt < ws);
   assign avm_readdata    = (avm_address == 5'd8) ? {24'd0, rrdy, trdy_en, 6'd0} :
                            (avm_address == 5'd0) ? {24'd0, rx_bytes[rd_cnt[5:0]]} :
                            32'hDEAD0000;

   uart_avm_controller dut (
      .avm_clk         (avm_clk),
      .avm_rst         (avm_rst),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .rx_stall        (rx_stall),
      .busy            (busy)
   );

   always @(posedge avm_clk) begin
      if ((avm_read | avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
      else                                            wcnt <= 0;

      if (avm_read && !avm_waitrequest) begin
         if (avm_address == 5'd8) st_cnt <= st_cnt + 1;
         else if (avm_address == 5'd0) begin
            rd_cnt        <= rd_cnt + 1;
            glog[gn[6:0]] <= 1'b0;
            gn            <= gn + 1;
         end
      end
      if (avm_write && !avm_waitrequest) begin
         wr_addr_log[wr_cnt[6:0]] <= avm_address;
         wr_data_log[wr_cnt[6:0]] <= avm_writedata;
         wr_cnt                   <= wr_cnt + 1;
         glog[gn[6:0]]            <= 1'b1;
         gn                       <= gn + 1;
      end
      if (tx_ready) txr_cnt <= txr_cnt + 1;
      if (rx_stall) stall_cnt <= stall_cnt + 1;
      if (rx_valid && rx_ready) begin
         pop_log[pop_cnt[6:0]] <= rx_data;
         pop_cnt               <= pop_cnt + 1;
      end

      if (avm_rst && (avm_read | avm_write) && avm_waitrequest) begin
         hold_q  <= 1'b1;
         ws_seen <= ws_seen + 1;
         s_addr  <= avm_address;
         s_rd    <= avm_read;
         s_wr    <= avm_write;
         s_wd    <= avm_writedata;
      end else begin
         hold_q <= 1'b0;
      end
      if (avm_rst && hold_q &&
          (s_addr != avm_address || s_rd != avm_read || s_wr != avm_write || s_wd != avm_writedata))
         stab_err <= stab_err + 1;
      if (avm_read && avm_write) stab_err <= stab_err + 1;
   end

   initial begin
      int r0, p0, wc0, l0, w0, s0, k0, t0;

      // Reset state
      repeat (3) @(negedge avm_clk);
      `CHK("rst_read", avm_read, 1'b0)
      `CHK("rst_write", avm_write, 1'b0)
      `CHK("rst_addr", avm_address, 5'd0)
      `CHK("rst_wdata", avm_writedata, 32'd0)
      `CHK("rst_busy", busy, 1'b0)
      `CHK("rst_rx_valid", rx_valid, 1'b0)
      `CHK("rst_rx_data", rx_data, 8'd0)
      `CHK("rst_tx_ready", tx_ready, 1'b0)
      `CHK("rst_rx_stall", rx_stall, 1'b0)

      // Single RX byte 0x41
      rx_bytes[0] = 8'h41;
      rx_req      = 1;
      avm_rst     = 1'b1;
      `WAITC(rx_valid, 30)
      `CHK("rx1_valid", rx_valid, 1'b1)
      `CHK("rx1_data", rx_data, 8'h41)
      `CHK("rx1_reads", rd_cnt, 1)
      rx_ready = 1'b1;
      @(negedge avm_clk);
      rx_ready = 1'b0;
      `CHK("rx1_pops", pop_cnt, 1)
      `CHK("rx1_popped", pop_log[0], 8'h41)
      `CHK("rx1_empty", rx_valid, 1'b0)

      // Single TX byte 0x5A
      `WAITC(!busy, 20)
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      trdy_en  = 1'b1;
      `WAITC(tx_ready, 30)
      `CHK("tx1_ready", tx_ready, 1'b1)
      `CHK("tx1_writes", wr_cnt, 1)
      `CHK("tx1_addr", wr_addr_log[0], 5'd4)
      `CHK("tx1_wdata", wr_data_log[0], 32'h0000005A)
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (20) @(negedge avm_clk);
      `CHK("tx1_one_pulse", txr_cnt, 1)
      `CHK("tx1_one_write", wr_cnt, 1)

      // Contention: RX and TX grants alternate, RX first (last grant was TX)
      `WAITC(!busy, 20)
      l0 = gn;
      r0 = rd_cnt;
      p0 = pop_cnt;
      for (int i = 0; i < 6; i++) rx_bytes[6'(r0 + i)] = 8'hA0 + 8'(i);
      rx_req   = r0 + 6;
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      rx_ready = 1'b1;
      `WAITC(rd_cnt == r0 + 6, 200)
      `WAITC(tx_ready, 30)
      tx_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic e;
         e = (i % 2 == 1);
         `CHK("rr_grant", glog[7'(l0 + i)], e)
      end
      repeat (5) @(negedge avm_clk);
      `CHK("rr_pops", pop_cnt, p0 + 6)
      for (int i = 0; i < 6; i++) begin
         `CHK("rr_pop_data", pop_log[7'(p0 + i)], 8'hA0 + 8'(i))
      end
      `CHK("rr_wdata", wr_data_log[7'(wr_cnt - 1)], 32'h00000011)

      // Three wait states on every access
      `WAITC(!busy, 20)
      ws  = 3;
      w0  = ws_seen;
      r0  = rd_cnt;
      wc0 = wr_cnt;
      rx_bytes[6'(r0)] = 8'h7E;
      rx_req = r0 + 1;
      `WAITC(rd_cnt == r0 + 1, 100)
      `WAITC(!busy, 20)
      tx_data  = 8'h99;
      tx_valid = 1'b1;
      `WAITC(tx_ready, 100)
      tx_valid = 1'b0;
      ws = 0;
      `CHK("ws_stable", stab_err, 0)
      `CHK("ws_reads", rd_cnt, r0 + 1)
      `CHK("ws_writes", wr_cnt, wc0 + 1)
      `CHK("ws_wdata", wr_data_log[7'(wc0)], 32'h00000099)
      `CHK("ws_seen", ((ws_seen - w0) >= 6), 1'b1)
      `CHK("ws_pop", pop_log[7'(pop_cnt - 1)], 8'h7E)

      // Fill FIFO to capacity, then one more byte pending in the UART
      `WAITC(!busy, 20)
      rx_ready = 1'b0;
      trdy_en  = 1'b0;
      r0 = rd_cnt;
      p0 = pop_cnt;
      for (int i = 0; i < 16; i++) rx_bytes[6'(r0 + i)] = 8'hC0 + 8'(i);
      rx_req = r0 + 16;
      `WAITC(rd_cnt == r0 + 16, 300)
      `CHK("full_valid", rx_valid, 1'b1)
      `CHK("full_head", rx_data, 8'hC0)
      rx_bytes[6'(r0 + 16)] = 8'hD0;
      rx_req = r0 + 17;
      `WAITC(avm_read && avm_address == 5'd8, 20)
      s0 = st_cnt;
      k0 = stall_cnt;
      `WAITC(st_cnt == s0 + 5, 100)
      repeat (3) @(negedge avm_clk);
      `CHK("full_stalls", stall_cnt - k0, 5)
      `CHK("full_no_read", rd_cnt, r0 + 16)
      rx_ready = 1'b1;
      `WAITC(pop_cnt == p0 + 17, 300)
      for (int i = 0; i < 16; i++) begin
         `CHK("full_pop_data", pop_log[7'(p0 + i)], 8'hC0 + 8'(i))
      end
      `CHK("full_pop_last", pop_log[7'(p0 + 16)], 8'hD0)

      // Asynchronous reset in the middle of a stalled read
      `WAITC(!busy, 20)
      rx_ready = 1'b0;
      r0 = rd_cnt;
      rx_bytes[6'(r0)] = 8'hE5;
      rx_req = r0 + 1;
      `WAITC(rx_valid, 40)
      `CHK("arst_pre_valid", rx_valid, 1'b1)
      ws = 50;
      `WAITC(avm_read, 20)
      `CHK("arst_pre_read", avm_read, 1'b1)
      #5 avm_rst = 1'b0;
      #1;
      `CHK("arst_read", avm_read, 1'b0)
      `CHK("arst_busy", busy, 1'b0)
      `CHK("arst_addr", avm_address, 5'd0)
      `CHK("arst_fifo", rx_valid, 1'b0)
      @(negedge avm_clk);
      ws      = 0;
      avm_rst = 1'b1;

      // Received byte 0x33 with transmitter ready: echo behaviour depends on build
      `WAITC(!busy, 20)
      trdy_en  = 1'b1;
      rx_ready = 1'b1;
      r0  = rd_cnt;
      wc0 = wr_cnt;
      t0  = txr_cnt;
      p0  = pop_cnt;
      rx_bytes[6'(r0)] = 8'h33;
      rx_req = r0 + 1;
      `WAITC(rd_cnt == r0 + 1, 40)
      repeat (20) @(negedge avm_clk);
`ifdef UART_CTRL_ECHO_EN
      `CHK("echo_writes", wr_cnt, wc0 + 1)
      `CHK("echo_addr", wr_addr_log[7'(wc0)], 5'd4)
      `CHK("echo_wdata", wr_data_log[7'(wc0)], 32'h00000033)
`else
      `CHK("noecho_writes", wr_cnt, wc0)
`endif
      `CHK("echo_no_txready", txr_cnt, t0)
      `CHK("echo_pops", pop_cnt, p0 + 1)
      `CHK("echo_pop_data", pop_log[7'(p0)], 8'h33)

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
